// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: pipeline stage register with a valid/ready handshake and a
// two-entry skid buffer (main register M drives the output, skid register S
// absorbs the one entry that arrives while downstream stalls). in_ready is a
// register, so upstream stall never depends combinationally on out_ready.
// Flush beats every other event and leaves a CLR_VALUE bubble behind.
// Optional build macro PIPE_STATS_EN adds saturating stall/flush counters.
module pipe_skid_stage #(
  parameter int unsigned      WIDTH     = 64,
  parameter logic [WIDTH-1:0] CLR_VALUE = '0,
  parameter int unsigned      CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_STATS_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
`endif
);

  if (WIDTH < 1 || WIDTH > 1024 || CNT_W < 1 || CNT_W > 32) begin : g_param_check
    $error("pipe_skid_stage: WIDTH must be 1..1024 and CNT_W 1..32");
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic [WIDTH-1:0] s_data_q, s_data_d;
  logic             m_vld_q, m_vld_d;
  logic             s_vld_q, s_vld_d;
  logic             in_ready_q, in_ready_d;
  logic             acc;
  logic             drn;

  assign acc       = in_valid & in_ready_q;
  assign drn       = m_vld_q & out_ready;
  assign in_ready  = in_ready_q;
  assign out_valid = m_vld_q;
  assign out_data  = m_data_q;

  // State, storage and registered handshake flags; reset empties the stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= EMPTY;
      m_data_q   <= CLR_VALUE;
      s_data_q   <= CLR_VALUE;
      m_vld_q    <= 1'b0;
      s_vld_q    <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      m_data_q   <= m_data_d;
      s_data_q   <= s_data_d;
      m_vld_q    <= m_vld_d;
      s_vld_q    <= s_vld_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Next state and storage moves; flush overrides accept and drain.
  always_comb begin
    state_d  = state_q;
    m_data_d = m_data_q;
    s_data_d = s_data_q;
    if (flush) begin
      state_d  = EMPTY;
      m_data_d = CLR_VALUE;
      s_data_d = CLR_VALUE;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (acc) begin
            state_d  = FULL;
            m_data_d = in_data;
          end
        end
        FULL: begin
          if (acc && drn) begin
            m_data_d = in_data;
          end else if (drn) begin
            state_d  = EMPTY;
            m_data_d = CLR_VALUE;
          end else if (acc) begin
            state_d  = SKID;
            s_data_d = in_data;
          end
        end
        SKID: begin
          // in_ready is low here, so only a drain can move the stage.
          if (drn) begin
            state_d  = FULL;
            m_data_d = s_data_q;
            s_data_d = CLR_VALUE;
          end
        end
        default: begin
          state_d  = EMPTY;
          m_data_d = CLR_VALUE;
          s_data_d = CLR_VALUE;
        end
      endcase
    end
    m_vld_d    = (state_d != EMPTY);
    s_vld_d    = (state_d == SKID);
    in_ready_d = (state_d != SKID);
  end

`ifdef PIPE_STATS_EN
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flcnt_q, flcnt_d;

  // Saturating counters; only reset clears them, flush does not.
  always_comb begin
    stall_d = stall_q;
    flcnt_d = flcnt_q;
    if (m_vld_q && !out_ready && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
    if (flush && (flcnt_q != {CNT_W{1'b1}})) begin
      flcnt_d = flcnt_q + CNT_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flcnt_q <= '0;
    end else begin
      stall_q <= stall_d;
      flcnt_q <= flcnt_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flcnt_q;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Testbench for pipe_skid_stage: directed scenario tasks plus a queue
// scoreboard that follows every accepted entry to the output.
module tb_pipe_skid_stage;

  localparam int unsigned W   = 8;
  localparam logic [W-1:0] CLR = 8'hC3;
  localparam int unsigned CW  = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_data;
`ifdef PIPE_STATS_EN
  logic [CW-1:0] stall_cycles;
  logic [CW-1:0] flush_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] sb[$];
  logic         hold_prev = 1'b0;
  logic [W-1:0] prev_data = '0;

  pipe_skid_stage #(.WIDTH(W), .CLR_VALUE(CLR), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef PIPE_STATS_EN
    , .stall_cycles(stall_cycles), .flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  // Scoreboard monitor: inputs are stable at the falling edge, so this sees
  // exactly what the next rising edge will act on.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        n_checks++;
        if (out_data !== prev_data) $display("FAIL stable_hold: out_data=%h required %h", out_data, prev_data);
        else n_pass++;
      end
      hold_prev = out_valid && !out_ready && !flush;
      prev_data = out_data;
      if (flush) begin
        sb.delete();
      end else begin
        if (out_valid && out_ready) begin
          n_checks++;
          if (sb.size() == 0) $display("FAIL sb_order: out_data=%h drained with no entry expected", out_data);
          else if (out_data !== sb[0]) begin $display("FAIL sb_order: out_data=%h required %h", out_data, sb[0]); void'(sb.pop_front()); end
          else begin n_pass++; void'(sb.pop_front()); end
        end
        if (in_valid && in_ready) sb.push_back(in_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: %b required 1", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: %b required 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== CLR) $display("FAIL rst_out_data: %h required %h", out_data, CLR); else n_pass++;
`ifdef PIPE_STATS_EN
    n_checks++; if (stall_cycles !== '0) $display("FAIL rst_stall: %0d required 0", stall_cycles); else n_pass++;
    n_checks++; if (flush_count !== '0) $display("FAIL rst_flcnt: %0d required 0", flush_count); else n_pass++;
`endif
    reset = 1'b0;
    repeat (3) tick();
    n_checks++; if (in_ready !== 1'b1) $display("FAIL idle_in_ready: %b required 1", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL idle_out_valid: %b required 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== CLR) $display("FAIL idle_out_data: %h required %h", out_data, CLR); else n_pass++;
  endtask

  task automatic test_stream();
    logic [W-1:0] exp_s [3];
    exp_s = '{8'h11, 8'h22, 8'h33};
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = exp_s[0];
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++; if (out_valid !== 1'b1) $display("FAIL stream_valid[%0d]: %b required 1", i, out_valid); else n_pass++;
      n_checks++; if (out_data !== exp_s[i]) $display("FAIL stream_data[%0d]: %h required %h", i, out_data, exp_s[i]); else n_pass++;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL stream_in_ready[%0d]: %b required 1", i, in_ready); else n_pass++;
      if (i < 2) in_data = exp_s[i+1];
      else in_valid = 1'b0;
    end
    tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL stream_end_valid: %b required 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== CLR) $display("FAIL stream_end_data: %h required %h", out_data, CLR); else n_pass++;
  endtask

  task automatic test_skid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hA1;
    tick();
    n_checks++; if (out_data !== 8'hA1) $display("FAIL skid_first: %h required a1", out_data); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL skid_rdy_full: %b required 1", in_ready); else n_pass++;
    in_data = 8'hA2;
    tick();
    in_valid = 1'b0;
    n_checks++; if (in_ready !== 1'b0) $display("FAIL skid_rdy_low: %b required 0", in_ready); else n_pass++;
    repeat (2) begin
      tick();
      n_checks++; if (out_data !== 8'hA1 || out_valid !== 1'b1) $display("FAIL skid_hold: v=%b d=%h required v=1 d=a1", out_valid, out_data); else n_pass++;
      n_checks++; if (in_ready !== 1'b0) $display("FAIL skid_hold_rdy: %b required 0", in_ready); else n_pass++;
    end
    out_ready = 1'b1;
    tick();
    n_checks++; if (out_data !== 8'hA2 || out_valid !== 1'b1) $display("FAIL skid_second: v=%b d=%h required v=1 d=a2", out_valid, out_data); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL skid_rdy_back: %b required 1", in_ready); else n_pass++;
    tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL skid_empty: %b required 0", out_valid); else n_pass++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hB1;
    tick();
    in_data = 8'hB2;
    tick();
    n_checks++; if (in_ready !== 1'b0) $display("FAIL flush_pre_skid: in_ready=%b required 0", in_ready); else n_pass++;
    flush     = 1'b1;
    out_ready = 1'b1;
    in_data   = 8'hFF;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL flush_valid: %b required 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== CLR) $display("FAIL flush_data: %h required %h", out_data, CLR); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL flush_in_ready: %b required 1", in_ready); else n_pass++;
    repeat (3) begin
      tick();
      n_checks++; if (out_valid !== 1'b0 || out_data === 8'hFF) $display("FAIL flush_after: v=%b d=%h required v=0", out_valid, out_data); else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h05;
    tick();
    in_data = 8'h06;
    tick();
    in_valid = 1'b0;
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL arst_valid: %b required 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== CLR) $display("FAIL arst_data: %h required %h", out_data, CLR); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL arst_in_ready: %b required 1", in_ready); else n_pass++;
    tick();
    reset = 1'b0;
    sb.delete();
    tick();
    n_checks++; if (out_valid !== 1'b0) $display("FAIL arst_after: %b required 0", out_valid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = W'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      tick();
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    n_checks++; if (sb.size() != 0) $display("FAIL b2b_lost: %0d entries undelivered, required 0", sb.size()); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL b2b_drained: %b required 0", out_valid); else n_pass++;
  endtask

`ifdef PIPE_STATS_EN
  task automatic test_stats();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h77;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    n_checks++; if (stall_cycles !== 2'd3) $display("FAIL stats_stall: %0d required 3", stall_cycles); else n_pass++;
    n_checks++; if (flush_count !== 2'd0) $display("FAIL stats_fl0: %0d required 0", flush_count); else n_pass++;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++; if (flush_count !== 2'd1) $display("FAIL stats_fl1: %0d required 1", flush_count); else n_pass++;
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    n_checks++; if (flush_count !== 2'd2) $display("FAIL stats_fl2: %0d required 2", flush_count); else n_pass++;
    n_checks++; if (stall_cycles !== 2'd3) $display("FAIL stats_stall_kept: %0d required 3", stall_cycles); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_skid();
    test_flush();
    test_async_reset();
    test_back_to_back();
`ifdef PIPE_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
